// File: rtl/burst_readout.sv
// Streams every sample out of a burst-packed RAM, from word 0 up to the last word, one sample per beat.
// Latency: read_latency + 1 cycles from an address change to the first sample of that word.
// Backpressure: sample_valid/sample_last/sample_out hold until sample_ready; up to one sample per cycle within a word.
module burst_readout #(
    parameter int no_of_digits    = 8,
    parameter int radix_bits      = 3,
    parameter int burst_index     = 8,
    parameter int address_width   = 14,
    parameter int max_ram_address = 16384,
    parameter int read_latency    = 2
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic                                                    start,
    output logic [address_width-1:0]                                ram_addr,
    input  logic [(no_of_digits+1)*radix_bits*burst_index-1:0]      ram_q,
    output logic [(no_of_digits+1)*radix_bits-1:0]                  sample_out,
    output logic                                                    sample_valid,
    input  logic                                                    sample_ready,
    output logic                                                    sample_last,
    output logic                                                    busy,
    output logic                                                    done
);

    localparam int w  = (no_of_digits + 1) * radix_bits;
    localparam int kw = (burst_index > 1) ? $clog2(burst_index) : 1;

    localparam logic [kw-1:0]          k_last    = kw'(burst_index - 1);
    localparam logic [address_width:0] word_last = (address_width + 1)'(max_ram_address - 1);
    localparam logic [2:0]             lat_last  = 3'(read_latency - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        EMIT,
        FINISH
    } state_t;

    state_t                           state;
    logic [burst_index-1:0][w-1:0]    buffer;
    logic [kw-1:0]                    k;
    // One bit wider than the address so a full 2^address_width sweep ends cleanly.
    logic [address_width:0]           word;
    logic [2:0]                       lat_cnt;
    logic                             word_end;
    logic [kw-1:0]                    k_next;

    assign word_end = (word == word_last);
    assign k_next   = k + kw'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            buffer       <= '0;
            k            <= '0;
            word         <= '0;
            lat_cnt      <= '0;
            ram_addr     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            sample_last  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        ram_addr <= '0;
                        word     <= '0;
                        lat_cnt  <= '0;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (lat_cnt == lat_last) begin
                        state   <= LOAD;
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                LOAD: begin
                    buffer       <= ram_q;
                    k            <= '0;
                    sample_out   <= ram_q[w-1:0];
                    sample_valid <= 1'b1;
                    sample_last  <= (k_last == '0) && word_end;
                    state        <= EMIT;
                end
                EMIT: begin
                    if (sample_valid && sample_ready) begin
                        if (k != k_last) begin
                            k           <= k_next;
                            sample_out  <= buffer[k_next];
                            sample_last <= (k_next == k_last) && word_end;
                        end else begin
                            sample_valid <= 1'b0;
                            sample_last  <= 1'b0;
                            if (word_end) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                ram_addr <= ram_addr + address_width'(1);
                                word     <= word + (address_width + 1)'(1);
                                state    <= FETCH;
                            end
                        end
                    end
                end
                FINISH: begin
                    // start is deliberately not looked at here; a new readout needs IDLE first.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_readout.sv
// Three readout engines (read latency 1, 2, 4) against a pipelined RAM model, with a per-engine sample scoreboard.
module tb_burst_readout;

    localparam int ND   = 8;
    localparam int RB   = 3;
    localparam int W    = (ND + 1) * RB;
    localparam int BI   = 2;
    localparam int AW   = 2;
    localparam int MAXA = 4;
    localparam int NS   = MAXA * BI;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic          rmode;
    logic          start_v   [3];
    logic [AW-1:0] ram_addr_v[3];
    logic [W-1:0]  so_v      [3];
    logic          sv_v      [3];
    logic          sl_v      [3];
    logic          busy_v    [3];
    logic          done_v    [3];

    exp_t          sb[3][$];
    int            checks   = 0;
    int            failures = 0;
    int            done_cnt[3] = '{0, 0, 0};
    int            xfer_cnt[3] = '{0, 0, 0};
    int            gap     [3] = '{0, 0, 0};
    logic          prev_vld [3];
    logic          prev_last[3];
    logic          prev_done[3];
    logic          pend_done[3];
    logic [W-1:0]  prev_dat [3];
    logic          prev_rdy;
    logic          rpat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [AW-1:0]   pipe[4];
        logic [BI*W-1:0] ram_q;

        always @(posedge clk) begin
            pipe[0] <= ram_addr_v[g];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        assign ram_q = {W'(2 * int'(pipe[LAT-1]) + 1), W'(2 * int'(pipe[LAT-1]))};

        burst_readout #(
            .no_of_digits   (ND),
            .radix_bits     (RB),
            .burst_index    (BI),
            .address_width  (AW),
            .max_ram_address(MAXA),
            .read_latency   (LAT)
        ) u_dut (
            .clk         (clk),
            .reset       (rst),
            .start       (start_v[g]),
            .ram_addr    (ram_addr_v[g]),
            .ram_q       (ram_q),
            .sample_out  (so_v[g]),
            .sample_valid(sv_v[g]),
            .sample_ready(ready),
            .sample_last (sl_v[g]),
            .busy        (busy_v[g]),
            .done        (done_v[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_readout(input int g);
        exp_t e;
        for (int s = 0; s < NS; s++) begin
            e.d = W'(s);
            e.l = (s == NS - 1);
            sb[g].push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) start_v[g] = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) start_v[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int target, input int budget);
        int n = 0;
        while (done_cnt[g] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("done_wait[%0d]", g), 64'(done_cnt[g] >= target), 64'(1));
    endtask

    task automatic chk_zero(input string ph);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_addr[%0d]", ph, g), 64'(ram_addr_v[g]), 64'(0));
            check($sformatf("%s_out[%0d]", ph, g), 64'(so_v[g]), 64'(0));
            check($sformatf("%s_valid[%0d]", ph, g), 64'(sv_v[g]), 64'(0));
            check($sformatf("%s_last[%0d]", ph, g), 64'(sl_v[g]), 64'(0));
            check($sformatf("%s_busy[%0d]", ph, g), 64'(busy_v[g]), 64'(0));
            check($sformatf("%s_done[%0d]", ph, g), 64'(done_v[g]), 64'(0));
        end
    endtask

    // Ready is either always high or cycles through the 1,0,0,1 pattern.
    initial begin
        int idx;
        idx   = 0;
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode) begin
                ready = rpat[idx % 4];
                idx++;
            end else begin
                ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                prev_vld[g]  = 1'b0;
                prev_last[g] = 1'b0;
                prev_done[g] = 1'b0;
                pend_done[g] = 1'b0;
                prev_dat[g]  = '0;
                gap[g]       = 0;
            end else begin
                if (pend_done[g]) begin
                    check($sformatf("done_after_last[%0d]", g), 64'(done_v[g]), 64'(1));
                    pend_done[g] = 1'b0;
                end
                if (done_v[g]) begin
                    done_cnt[g]++;
                    check($sformatf("done_one_cycle[%0d]", g), 64'(prev_done[g]), 64'(0));
                end
                if (prev_vld[g] && !prev_rdy) begin
                    check($sformatf("stall_valid[%0d]", g), 64'(sv_v[g]), 64'(1));
                    check($sformatf("stall_data[%0d]", g), 64'(so_v[g]), 64'(prev_dat[g]));
                    check($sformatf("stall_last[%0d]", g), 64'(sl_v[g]), 64'(prev_last[g]));
                end
                if (sv_v[g] && !prev_vld[g])
                    check($sformatf("load_latency[%0d]", g), 64'(gap[g]), 64'(lat_of(g) + 1));
                if (done_v[g] || !busy_v[g] || sv_v[g]) gap[g] = 0;
                else gap[g]++;
                if (sv_v[g] && ready) begin
                    check($sformatf("sample_expected[%0d]", g), 64'(sb[g].size() > 0), 64'(1));
                    if (sb[g].size() > 0) begin
                        exp_t e;
                        e = sb[g].pop_front();
                        check($sformatf("data[%0d]", g), 64'(so_v[g]), 64'(e.d));
                        check($sformatf("last[%0d]", g), 64'(sl_v[g]), 64'(e.l));
                        check($sformatf("addr[%0d]", g), 64'(ram_addr_v[g]), 64'(e.d / W'(BI)));
                        if (e.l) pend_done[g] = 1'b1;
                    end
                    xfer_cnt[g]++;
                end
                prev_vld[g]  = sv_v[g];
                prev_dat[g]  = so_v[g];
                prev_last[g] = sl_v[g];
                prev_done[g] = done_v[g];
            end
        end
        prev_rdy = ready;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int  xb[3];
        int  n;
        logic found;

        rst   = 1'b1;
        rmode = 1'b0;
        for (int g = 0; g < 3; g++) start_v[g] = 1'b0;

        // Reset acts before any clock edge.
        #3;
        chk_zero("reset");
        repeat (2) @(negedge clk);

        // Plain readout, start raised between edges right as reset drops.
        for (int g = 0; g < 3; g++) push_readout(g);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) start_v[g] = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) check($sformatf("start_after_reset[%0d]", g), 64'(busy_v[g]), 64'(1));
        for (int g = 0; g < 3; g++) start_v[g] = 1'b0;
        for (int g = 0; g < 3; g++) wait_done(g, 1, 300);
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("xfers_a[%0d]", g), 64'(xfer_cnt[g]), 64'(NS));
            check($sformatf("dones_a[%0d]", g), 64'(done_cnt[g]), 64'(1));
            check($sformatf("no_wrap_a[%0d]", g), 64'(ram_addr_v[g]), 64'(MAXA - 1));
        end

        // Stalling consumer, plus a stray start mid-readout.
        rmode = 1'b1;
        for (int g = 0; g < 3; g++) begin
            xb[g] = xfer_cnt[g];
            push_readout(g);
        end
        pulse_start();
        repeat (12) @(posedge clk);
        pulse_start();
        for (int g = 0; g < 3; g++) wait_done(g, 2, 400);
        repeat (15) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("xfers_b[%0d]", g), 64'(xfer_cnt[g] - xb[g]), 64'(NS));
            check($sformatf("dones_b[%0d]", g), 64'(done_cnt[g]), 64'(2));
            check($sformatf("idle_b[%0d]", g), 64'(busy_v[g]), 64'(0));
        end
        rmode = 1'b0;

        // Reset between edges while the latency-2 engine shows word 2, sample 1.
        for (int g = 0; g < 3; g++) push_readout(g);
        pulse_start();
        found = 1'b0;
        n = 0;
        while (!found && n < 300) begin
            @(negedge clk);
            n++;
            if (sv_v[1] && so_v[1] == W'(5)) found = 1'b1;
        end
        check("mid_point_found", 64'(found), 64'(1));
        check("mid_addr", 64'(ram_addr_v[1]), 64'(2));
        #2;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) sb[g].delete();
        #1;
        chk_zero("mid_reset");
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) check($sformatf("no_done_abort[%0d]", g), 64'(done_cnt[g]), 64'(2));
        rst = 1'b0;
        for (int g = 0; g < 3; g++) push_readout(g);
        pulse_start();
        for (int g = 0; g < 3; g++) wait_done(g, 3, 300);

        // Start held high on one engine: it must pass through IDLE between readouts.
        xb[1] = xfer_cnt[1];
        push_readout(1);
        push_readout(1);
        @(posedge clk);
        #1;
        start_v[1] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_v[1] && n < 300);
        check("held_first_done", 64'(done_v[1]), 64'(1));
        @(negedge clk);
        check("held_idle_gap", 64'(busy_v[1]), 64'(0));
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        wait_done(1, 5, 300);
        repeat (5) @(negedge clk);
        check("held_xfers", 64'(xfer_cnt[1] - xb[1]), 64'(2 * NS));
        check("held_other_idle", 64'(busy_v[0]), 64'(0));

        for (int g = 0; g < 3; g++) begin
            check($sformatf("sb_empty[%0d]", g), 64'(sb[g].size()), 64'(0));
            check($sformatf("final_addr[%0d]", g), 64'(ram_addr_v[g]), 64'(MAXA - 1));
            check($sformatf("final_idle[%0d]", g), 64'(busy_v[g]), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/burst_readout.md
BURST_READOUT -- requirements
Module: burst_readout

Interface
REQ-001 SHALL have parameter no_of_digits, default 8, digits per stored sample excluding carry digit.
REQ-002 SHALL have parameter radix_bits, default 3, bits per signed digit.
REQ-003 SHALL have parameter burst_index, default 8, samples packed per RAM word.
REQ-004 SHALL have parameter address_width, default 14, RAM address width.
REQ-005 SHALL have parameter max_ram_address, default 16384, words read per readout (addresses 0..max_ram_address-1).
REQ-006 SHALL have parameter read_latency, default 2, clk edges from ram_addr change to valid ram_q; legal range 1..4.
REQ-007 SHALL use one clock and an asynchronous, active-high reset; ports listed below.
REQ-008 clk  input  1  sole clock; all state updates on rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 start  input  1  readout request, sampled in IDLE only.
REQ-011 ram_addr  output  address_width  RAM read address.
REQ-012 ram_q  input  W*burst_index, W=(no_of_digits+1)*radix_bits  RAM read data.
REQ-013 sample_out  output  W  current sample {cout digit, dout digits}.
REQ-014 sample_valid  output  1  sample_out holds a valid sample.
REQ-015 sample_ready  input  1  downstream accepts sample_out.
REQ-016 sample_last  output  1  high with sample_valid on final sample of readout.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse after final sample accepted.

Function
REQ-019 SHALL implement states IDLE, FETCH, LOAD, EMIT, FINISH.
REQ-020 IDLE: start=1 -> FETCH with ram_addr=0, word counter=0; start=0 -> stay.
REQ-021 FETCH SHALL hold ram_addr stable and count read_latency edges, then -> LOAD.
REQ-022 LOAD SHALL capture ram_q into internal word buffer, clear sample index to 0, -> EMIT in one cycle.
REQ-023 Sample k SHALL be buffer bits [(k+1)*W-1 : k*W]; k=0 emitted first, k=burst_index-1 last.
REQ-024 EMIT SHALL drive sample_valid=1 and sample_out=sample k from the captured buffer (no dependence on live ram_q).
REQ-025 Transfer occurs on an edge where sample_valid=1 and sample_ready=1; else sample_out, sample_last held unchanged.
REQ-026 sample_valid SHALL not deassert in EMIT until transfer; sample_valid SHALL not depend combinationally on sample_ready.
REQ-027 Transfer with k<burst_index-1 -> k+1, stay EMIT; back-to-back transfers SHALL sustain one sample per cycle within a word.
REQ-028 Transfer with k=burst_index-1 and word<max_ram_address-1 -> ram_addr+1, word+1, FETCH.
REQ-029 Transfer with k=burst_index-1 and word=max_ram_address-1 -> FINISH; sample_last=1 exactly on that sample.
REQ-030 FINISH SHALL assert done for exactly one cycle, then -> IDLE; ram_addr SHALL remain at max_ram_address-1 until next start.
REQ-031 Word counter SHALL be address_width+1 bits so max_ram_address=2^address_width terminates without wrap.
REQ-032 start outside IDLE SHALL be ignored; start during FINISH SHALL not retrigger.
REQ-033 sample_valid SHALL be 0 in IDLE, FETCH, LOAD, FINISH; sample_out SHALL hold last value outside EMIT.
REQ-034 Every readout SHALL emit exactly max_ram_address*burst_index samples, order ascending address then ascending k.

Reset
REQ-035 reset=1 SHALL immediately, without clk, force IDLE, ram_addr=0, sample_out=0, sample_valid=0, sample_last=0, busy=0, done=0, counters=0, buffer=0.
REQ-036 reset asserted mid-readout SHALL abandon the readout; no done pulse; next start restarts at address 0.
REQ-037 First start SHALL be honoured on the first rising edge after reset deasserts.

Verification
REQ-038 Params max_ram_address=4, burst_index=2, read_latency=2; RAM model word a = {2a+1, 2a}; start pulse, sample_ready=1 -> samples 0..7 in order, sample_last on 7, done one cycle later, 8 transfers total.
REQ-039 Same setup, sample_ready toggling 1,0,0,1 -> sample_out and sample_valid stable on stall cycles, no duplicated or dropped sample.
REQ-040 read_latency=1 and 4 -> LOAD occurs exactly 1 resp. 4 edges after ram_addr changes; data matches model.
REQ-041 reset asserted with ram_addr=2, k=1, between clk edges -> all outputs 0 before next edge; no done; next start yields sample 0 first.
REQ-042 start held high continuously -> second readout begins only after IDLE re-entered; start pulse during EMIT ignored.
REQ-043 address_width=2, max_ram_address=4 -> readout stops after address 3, no wrap to 0, done pulses once.
